hh_gate_bank: RTL and testbench

Time-multiplexed Hodgkin-Huxley gating-variable integrator for N_CH channels. Per channel it keeps a fixed-point gate value x in [0, 1] and advances it by one forward-Euler step per request. The rates alpha(V) and beta(V) are clamped linear functions of membrane potential, so one instance parameterised per gate type (n, m, h) serves every neuron in the population. It replaces the single-channel n-gate updater. It adds a valid/ready request interface, per-channel state, a load operation, saturation, and fully defined widths.

---
 rtl/hh_gate_bank.sv | 178 +++++++++++++++++
 tb/tb_hh_gate_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hh_gate_bank.sv
// -----------------------------------------------------------------------------
// hh_gate_bank
//
// Time-multiplexed Hodgkin-Huxley gating-variable integrator. Each of N_CH
// channels holds an unsigned Q(FRAC) gate value x in [0, ONE]. An update
// request (op 0) advances that value by one forward-Euler step:
//   alpha = clamp(ALPHA_K*(V-ALPHA_V0) + ALPHA_B, 0, RATE_MAX)
//   beta  = clamp(BETA_K *(V-BETA_V0)  + BETA_B,  0, RATE_MAX)
//   dxdt  = sat_W((alpha*(ONE-x) - beta*x) >>> FRAC)
//   x     = clamp(x + ((dxdt*dt) >>> FRAC), 0, ONE)
// A load request (op 1) writes clamp(in_v, 0, ONE) straight into the channel.
// Instantiate once per gate type (n, m, h) with that gate's rate constants.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   request ready (high only while idle)
//   in_op      0 = Euler update, 1 = load
//   in_ch      channel index
//   in_v       op 0: membrane potential (integer mV); op 1: value to load
//   in_dt      step size, unsigned Q(FRAC) ms
//   out_valid  one-cycle result strobe (no backpressure)
//   out_ch     channel of the most recent result (held)
//   out_x      new x of that channel (held)
// -----------------------------------------------------------------------------
module hh_gate_bank #(
  parameter int W        = 16,
  parameter int FRAC     = 10,
  parameter int N_CH     = 4,
  parameter int X_INIT   = 325,
  parameter int ALPHA_K  = 10,
  parameter int ALPHA_V0 = -65,
  parameter int ALPHA_B  = 102,
  parameter int BETA_K   = -2,
  parameter int BETA_V0  = -65,
  parameter int BETA_B   = 128,
  parameter int RATE_MAX = 4095,
  localparam int CHW     = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_op,
  input  logic [CHW-1:0]      in_ch,
  input  logic signed [W-1:0] in_v,
  input  logic [W-1:0]        in_dt,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic [W-1:0]        out_x
);

  // Intermediate width: the largest product (rate * ONE or dxdt * dt) needs
  // under 2W bits; the extra headroom keeps every sum exact before clamping.
  localparam int WI = 2 * W + 4;
  typedef logic signed [WI-1:0] wide_t;

  localparam wide_t ZERO_W     = wide_t'(0);
  localparam wide_t ONE_W      = wide_t'(1) <<< FRAC;
  localparam wide_t RATE_MAX_W = wide_t'(RATE_MAX);
  localparam wide_t SAT_MAX_W  = (wide_t'(1) <<< (W - 1)) - wide_t'(1);
  localparam wide_t SAT_MIN_W  = -SAT_MAX_W - wide_t'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RATE  = 3'd1;
  localparam logic [2:0] S_DERIV = 3'd2;
  localparam logic [2:0] S_UPD   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CHW-1:0]      ch_q;
  logic signed [W-1:0] v_q;
  logic [W-1:0]        dt_q;
  logic [W-1:0]        alpha_q, beta_q;
  logic signed [W-1:0] dxdt_q;
  logic [W-1:0]        x_q [N_CH];
  logic                out_valid_q;
  logic [CHW-1:0]      out_ch_q;
  logic [W-1:0]        out_x_q;

  logic [W-1:0]        alpha_d, beta_d, x_new, load_val;
  logic signed [W-1:0] dxdt_d;
  wide_t               x_cur, alpha_raw, beta_raw, deriv_raw, delta;

  function automatic wide_t clamp(input wide_t val, input wide_t lo, input wide_t hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_x     = out_x_q;

  // Next state. In IDLE in_ready is high, so in_valid alone means acceptance.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = in_op ? S_DONE : S_RATE;
      S_RATE:  state_d = S_DERIV;
      S_DERIV: state_d = S_UPD;
      S_UPD:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath. The channel's stored x is stable from acceptance until the
  // write at UPD->DONE, so DERIV and UPD both read it directly.
  always_comb begin
    x_cur     = wide_t'(x_q[ch_q]);
    alpha_raw = wide_t'(ALPHA_K) * (wide_t'(v_q) - wide_t'(ALPHA_V0)) + wide_t'(ALPHA_B);
    beta_raw  = wide_t'(BETA_K)  * (wide_t'(v_q) - wide_t'(BETA_V0))  + wide_t'(BETA_B);
    alpha_d   = W'(clamp(alpha_raw, ZERO_W, RATE_MAX_W));
    beta_d    = W'(clamp(beta_raw,  ZERO_W, RATE_MAX_W));
    // >>> on a signed operand floors toward minus infinity.
    deriv_raw = (wide_t'(alpha_q) * (ONE_W - x_cur) - wide_t'(beta_q) * x_cur) >>> FRAC;
    dxdt_d    = W'(clamp(deriv_raw, SAT_MIN_W, SAT_MAX_W));
    delta     = (wide_t'(dxdt_q) * wide_t'(dt_q)) >>> FRAC;
    x_new     = W'(clamp(x_cur + delta, ZERO_W, ONE_W));
    load_val  = W'(clamp(wide_t'(in_v), ZERO_W, ONE_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      v_q         <= '0;
      dt_q        <= '0;
      alpha_q     <= '0;
      beta_q      <= '0;
      dxdt_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_x_q     <= '0;
      // NOTE: the channel store is a handful of flops, not a RAM, so it is
      // reset in place; that is what restores every x to X_INIT.
      for (int i = 0; i < N_CH; i++) x_q[i] <= W'(X_INIT);
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from pre-edge values regardless of statement order.
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ch_q <= in_ch;
            v_q  <= in_v;
            dt_q <= in_dt;
            if (in_op) begin
              x_q[in_ch]  <= load_val;
              out_x_q     <= load_val;
              out_ch_q    <= in_ch;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_RATE: begin
          alpha_q <= alpha_d;
          beta_q  <= beta_d;
        end
        S_DERIV: dxdt_q <= dxdt_d;
        S_UPD: begin
          x_q[ch_q]   <= x_new;
          out_x_q     <= x_new;
          out_ch_q    <= ch_q;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hh_gate_bank.sv
module tb_hh_gate_bank;

  localparam int W = 16, FRAC = 10, N_CH = 4, CHW = 2, X_INIT = 325;
  localparam longint ALPHA_K = 10, ALPHA_V0 = -65, ALPHA_B = 102;
  localparam longint BETA_K = -2, BETA_V0 = -65, BETA_B = 128;
  localparam longint RATE_MAX = 4095;
  localparam longint ONE = 64'sd1 << FRAC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_op = 1'b0;
  logic in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic signed [W-1:0] in_v = '0;
  logic [W-1:0] in_dt = '0;
  logic out_valid;
  logic [CHW-1:0] out_ch;
  logic [W-1:0] out_x;

  hh_gate_bank #(
    .W(W), .FRAC(FRAC), .N_CH(N_CH), .X_INIT(X_INIT),
    .ALPHA_K(10), .ALPHA_V0(-65), .ALPHA_B(102),
    .BETA_K(-2), .BETA_V0(-65), .BETA_B(128), .RATE_MAX(4095)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_ch(in_ch), .in_v(in_v), .in_dt(in_dt),
    .out_valid(out_valid), .out_ch(out_ch), .out_x(out_x)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     ch;
    longint x;
    int     acc;
    int     lat;
  } exp_t;
  exp_t sb_q[$];

  longint model_x[N_CH];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: one forward-Euler step straight from the rate equations.
  function automatic longint model_step(input longint x, input longint v, input longint dt);
    longint a, b, d;
    a = clampl(ALPHA_K * (v - ALPHA_V0) + ALPHA_B, 0, RATE_MAX);
    b = clampl(BETA_K * (v - BETA_V0) + BETA_B, 0, RATE_MAX);
    d = (a * (ONE - x) - b * x) >>> FRAC;
    d = clampl(d, -(64'sd1 << (W - 1)), (64'sd1 << (W - 1)) - 1);
    return clampl(x + ((d * dt) >>> FRAC), 0, ONE);
  endfunction

  // Monitor: every result strobe must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_ch=%0d out_x=%0d with nothing outstanding (cycle %0d)",
                   out_ch, out_x, cyc);
        end else begin
          e = sb_q.pop_front();
          check("out_ch", out_ch, e.ch);
          check("out_x", out_x, e.x);
          check("latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue(input bit op, input int ch, input int v, input int dt);
    int waited = 0;
    int lat;
    longint e;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_ch    = CHW'(ch);
    in_v     = W'(v);
    in_dt    = W'(dt);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %b for %0d cycles", in_ready, waited);
      in_valid = 1'b0;
      return;
    end
    e = op ? clampl(v, 0, ONE) : model_step(model_x[ch], v, dt);
    model_x[ch] = e;
    lat = op ? 1 : 4;
    sb_q.push_back('{ch, e, cyc, lat});
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      check($sformatf("in_ready_cycle%0d", k), in_ready, (k == lat + 1) ? 1 : 0);
    end
    check("out_x_hold", out_x, e);
  endtask

  initial begin
    int drain;
    for (int i = 0; i < N_CH; i++) model_x[i] = X_INIT;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_x", out_x, 0);
    check("reset_out_ch", out_ch, 0);

    // Nominal updates on ch 0, then zero-dt reads of the untouched channels.
    issue(0, 0, -65, 1024);
    issue(0, 0, -65, 512);
    for (int c = 1; c < N_CH; c++) issue(0, c, -65, 0);

    // Saturation at both ends.
    issue(0, 1, 100, 1024);
    issue(0, 2, -200, 4096);

    // Loads with in_valid held high across DONE: a second acceptance only in IDLE.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b1; in_ch = 2'd3; in_v = 16'sd2000; in_dt = '0;
    check("hold_ready_c0", in_ready, 1);
    sb_q.push_back('{3, clampl(2000, 0, ONE), cyc, 1});
    model_x[3] = clampl(2000, 0, ONE);
    @(negedge clk);
    check("hold_ready_c1", in_ready, 0);
    in_v = -16'sd5;
    @(negedge clk);
    check("hold_ready_c2", in_ready, 1);
    sb_q.push_back('{3, clampl(-5, 0, ONE), cyc, 1});
    model_x[3] = clampl(-5, 0, ONE);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_ready_c3", in_ready, 0);
    @(negedge clk);
    check("hold_out_x", out_x, 0);

    // Abort an update during DERIV with reset.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_ch = 2'd0; in_v = -16'sd65; in_dt = 16'd1024;
    check("abort_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < N_CH; i++) model_x[i] = X_INIT;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_x", out_x, 0);
    for (int c = 0; c < N_CH; c++) issue(0, c, -65, 0);

    // Randomized mix of updates and loads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        issue(1, int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 1300)) - 100, 0);
      else
        issue(0, int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 300)) - 200,
              int'($urandom_range(0, 4095)));
    end

    drain = 0;
    while (sb_q.size() != 0 && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
